// File: rtl/lowres_cmd_pkg.sv
// rtl/lowres_cmd_pkg.sv - opcode, payload-type and state definitions shared by the responder and the adapter
package lowres_cmd_pkg;

    localparam int PK_WORDS   = 328;
    localparam int SK_WORDS   = 640;
    localparam int SIG_WORDS  = 605;
    localparam int SEED_WORDS = 8;

    // STOR/LOAD are 2-bit opcodes in op[3:2]; the rest use all four bits
    localparam logic [1:0] OPCODE_STOR         = 2'b11;
    localparam logic [1:0] OPCODE_LOAD         = 2'b10;
    localparam logic [3:0] OPCODE_IDLE         = 4'b0000;
    localparam logic [3:0] OPCODE_DIGEST_MSG   = 4'b0001;
    localparam logic [3:0] OPCODE_SIGN         = 4'b0010;
    localparam logic [3:0] OPCODE_SIGN_PRECOMP = 4'b0011;
    localparam logic [3:0] OPCODE_VRFY         = 4'b0100;
    localparam logic [3:0] OPCODE_VRFY_PRECOMP = 4'b0101;
    localparam logic [3:0] OPCODE_ILLEGAL      = 4'b0110;
    localparam logic [3:0] OPCODE_KGEN         = 4'b0111;

    localparam logic [1:0] TYPE_PK   = 2'b00;
    localparam logic [1:0] TYPE_SK   = 2'b01;
    localparam logic [1:0] TYPE_SIG  = 2'b10;
    localparam logic [1:0] TYPE_SEED = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_XFER       = 2'd1,
        ST_EXEC_START = 2'd2,
        ST_EXEC_WAIT  = 2'd3
    } resp_state_t;

    function automatic logic op_is_compute(input logic [3:0] op);
        return (op[3] == 1'b0) && (op != OPCODE_IDLE) && (op != OPCODE_ILLEGAL);
    endfunction

    function automatic logic [9:0] xfer_len(input logic [1:0] ptype);
        case (ptype)
            TYPE_PK:  return 10'(PK_WORDS);
            TYPE_SK:  return 10'(SK_WORDS);
            TYPE_SIG: return 10'(SIG_WORDS);
            default:  return 10'(SEED_WORDS);
        endcase
    endfunction

endpackage

// File: rtl/lowres_cmd_responder_beat_counter.sv
// rtl/lowres_cmd_responder_beat_counter.sv - lowres_beat_counter: 10-bit word index with clear, increment and last-word compare
module lowres_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       incr,
    input  logic [9:0] len,
    output logic [9:0] count,
    output logic       last
);

    assign last = (count == (len - 10'd1));

    // Wraps to 0 on the final word so the next transfer starts clean
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 10'd0;
        end else if (incr) begin
            count <= last ? 10'd0 : count + 10'd1;
        end
    end

endmodule

// File: rtl/lowres_cmd_responder.sv
// rtl/lowres_cmd_responder.sv - opcode decoder/sequencer for store, load and compute; LOWRES_CMD_ERR_EN enables op_err
module lowres_cmd_responder
    import lowres_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] op_in,
    input  logic       op_valid_in,
    output logic       ready_out,
    output logic       xfer_active,
    output logic       xfer_dir,
    output logic [1:0] xfer_type,
    output logic [9:0] xfer_idx,
    input  logic       xfer_beat,
    output logic       exec_start,
    output logic [3:0] exec_op,
    input  logic       exec_done,
    output logic       op_err
);

    resp_state_t state_q, state_d;
    logic        accept;
    logic        accept_xfer;
    logic        accept_exec;
    logic        last_word;

    assign accept      = (state_q == ST_IDLE) && op_valid_in;
    assign accept_xfer = accept && op_in[3];
    assign accept_exec = accept && op_is_compute(op_in);

    assign ready_out   = (state_q == ST_IDLE);
    assign xfer_active = (state_q == ST_XFER);
    assign exec_start  = (state_q == ST_EXEC_START);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_xfer)      state_d = ST_XFER;
                else if (accept_exec) state_d = ST_EXEC_START;
            end
            ST_XFER:       if (xfer_beat && last_word) state_d = ST_IDLE;
            ST_EXEC_START: state_d = ST_EXEC_WAIT;
            ST_EXEC_WAIT:  if (exec_done) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            xfer_dir  <= 1'b0;
            xfer_type <= TYPE_PK;
            exec_op   <= OPCODE_IDLE;
        end else begin
            state_q <= state_d;
            if (accept_xfer) begin
                xfer_dir  <= (op_in[3:2] == OPCODE_STOR);
                xfer_type <= op_in[1:0];
            end
            if (accept_exec) begin
                exec_op <= op_in;
            end
        end
    end

    lowres_beat_counter u_beat_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (accept_xfer),
        .incr  (xfer_active && xfer_beat),
        .len   (xfer_len(xfer_type)),
        .count (xfer_idx),
        .last  (last_word)
    );

`ifdef LOWRES_CMD_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_err <= 1'b0;
        end else if (accept && (op_in == OPCODE_ILLEGAL)) begin
            op_err <= 1'b1;
        end
    end
`else
    assign op_err = 1'b0;
`endif

endmodule

// File: tb/tb_lowres_cmd_responder.sv
// tb/tb_lowres_cmd_responder.sv - directed self-checking bench for lowres_cmd_responder
module tb_lowres_cmd_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] op_in = 4'b0000;
    logic       op_valid_in = 1'b0;
    logic       ready_out;
    logic       xfer_active;
    logic       xfer_dir;
    logic [1:0] xfer_type;
    logic [9:0] xfer_idx;
    logic       xfer_beat = 1'b0;
    logic       exec_start;
    logic [3:0] exec_op;
    logic       exec_done = 1'b0;
    logic       op_err;

    int checks = 0;
    int errors = 0;

    lowres_cmd_responder dut (
        .clk         (clk),
        .rst         (rst),
        .op_in       (op_in),
        .op_valid_in (op_valid_in),
        .ready_out   (ready_out),
        .xfer_active (xfer_active),
        .xfer_dir    (xfer_dir),
        .xfer_type   (xfer_type),
        .xfer_idx    (xfer_idx),
        .xfer_beat   (xfer_beat),
        .exec_start  (exec_start),
        .exec_op     (exec_op),
        .exec_done   (exec_done),
        .op_err      (op_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_out); end
        checks++;
        if ({xfer_active, xfer_dir, xfer_type, xfer_idx, exec_start, exec_op, op_err} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs got act=%b dir=%b type=%b idx=%0d start=%b op=%b err=%b exp all 0",
                     xfer_active, xfer_dir, xfer_type, xfer_idx, exec_start, exec_op, op_err);
        end
    endtask

    task automatic test_store_seed();
        op_in = 4'b1111; op_valid_in = 1'b1;
        cyc();
        op_valid_in = 1'b0;
        checks++;
        if ({ready_out, xfer_active, xfer_dir, xfer_type} !== 5'b01111) begin
            errors++;
            $display("FAIL seed_accept got rdy=%b act=%b dir=%b type=%b exp 0 1 1 11",
                     ready_out, xfer_active, xfer_dir, xfer_type);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (xfer_idx !== 10'(i) || ready_out !== 1'b0) begin
                errors++;
                $display("FAIL seed_idx got idx=%0d rdy=%b exp idx=%0d rdy=0", xfer_idx, ready_out, i);
            end
            xfer_beat = 1'b1;
            cyc();
            xfer_beat = 1'b0;
        end
        checks++;
        if (ready_out !== 1'b1 || xfer_idx !== 10'd0 || xfer_active !== 1'b0) begin
            errors++;
            $display("FAIL seed_done got rdy=%b idx=%0d act=%b exp 1 0 0", ready_out, xfer_idx, xfer_active);
        end
    endtask

    task automatic test_kgen();
        op_in = 4'b0111; op_valid_in = 1'b1;
        cyc();
        op_valid_in = 1'b0;
        checks++;
        if (exec_start !== 1'b1 || exec_op !== 4'b0111 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL kgen_start got start=%b op=%b rdy=%b exp 1 0111 0", exec_start, exec_op, ready_out);
        end
        cyc();
        checks++;
        if (exec_start !== 1'b0) begin errors++; $display("FAIL kgen_pulse got %b exp 0", exec_start); end
        repeat (49) cyc();
        checks++;
        if (ready_out !== 1'b0 || exec_op !== 4'b0111) begin
            errors++;
            $display("FAIL kgen_wait got rdy=%b op=%b exp 0 0111", ready_out, exec_op);
        end
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL kgen_done got rdy=%b exp 1", ready_out); end
    endtask

    task automatic test_keygen_seq();
        logic [3:0] ops  [4] = '{4'b1111, 4'b0111, 4'b1001, 4'b1000};
        int         lens [4] = '{8, 0, 640, 328};
        for (int s = 0; s < 4; s++) begin
            int n;
            op_in = ops[s]; op_valid_in = 1'b1;
            cyc();
            op_valid_in = 1'b0;
            checks++;
            if (ready_out !== 1'b0) begin
                errors++;
                $display("FAIL seq_accept step %0d got rdy=%b exp 0", s, ready_out);
            end
            n = 0;
            if (lens[s] == 0) begin
                cyc();
                exec_done = 1'b1;
                cyc();
                exec_done = 1'b0;
                n = 3;
                lens[s] = 3;
            end else begin
                xfer_beat = 1'b1;
                while (ready_out !== 1'b1 && n < 2000) begin
                    cyc();
                    n++;
                end
                xfer_beat = 1'b0;
            end
            checks++;
            if (n !== lens[s] || ready_out !== 1'b1) begin
                errors++;
                $display("FAIL seq_count step %0d got %0d cycles rdy=%b exp %0d rdy=1", s, n, ready_out, lens[s]);
            end
        end
    endtask

    task automatic test_ignored();
        int n;
        op_in = 4'b0010; op_valid_in = 1'b1;
        cyc();
        op_valid_in = 1'b0;
        cyc();
        op_in = 4'b1010; op_valid_in = 1'b1;
        cyc();
        op_valid_in = 1'b0;
        checks++;
        if (ready_out !== 1'b0 || xfer_active !== 1'b0 || xfer_type !== 2'b00 || exec_op !== 4'b0010) begin
            errors++;
            $display("FAIL wait_ignore_op got rdy=%b act=%b type=%b op=%b exp 0 0 00 0010",
                     ready_out, xfer_active, xfer_type, exec_op);
        end
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;
        xfer_beat = 1'b1;
        cyc();
        xfer_beat = 1'b0;
        checks++;
        if (ready_out !== 1'b1 || xfer_idx !== 10'd0) begin
            errors++;
            $display("FAIL idle_ignore_beat got rdy=%b idx=%0d exp 1 0", ready_out, xfer_idx);
        end
        op_in = 4'b1110; op_valid_in = 1'b1;
        cyc();
        op_valid_in = 1'b0;
        xfer_beat = 1'b1;
        repeat (3) cyc();
        xfer_beat = 1'b0;
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;
        checks++;
        if (xfer_active !== 1'b1 || xfer_idx !== 10'd3 || xfer_type !== 2'b10 || xfer_dir !== 1'b1) begin
            errors++;
            $display("FAIL xfer_ignore_done got act=%b idx=%0d type=%b dir=%b exp 1 3 10 1",
                     xfer_active, xfer_idx, xfer_type, xfer_dir);
        end
        xfer_beat = 1'b1;
        repeat (601) cyc();
        checks++;
        if (ready_out !== 1'b0 || xfer_idx !== 10'd604) begin
            errors++;
            $display("FAIL sig_last got rdy=%b idx=%0d exp 0 604", ready_out, xfer_idx);
        end
        n = 0;
        while (ready_out !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        xfer_beat = 1'b0;
        checks++;
        if (n !== 1) begin errors++; $display("FAIL sig_end got %0d cycles exp 1", n); end
    endtask

    task automatic test_illegal();
        logic exp_err;
`ifdef LOWRES_CMD_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        op_in = 4'b0110; op_valid_in = 1'b1;
        cyc();
        op_valid_in = 1'b0;
        checks++;
        if (ready_out !== 1'b1 || xfer_active !== 1'b0 || exec_start !== 1'b0 || op_err !== exp_err) begin
            errors++;
            $display("FAIL illegal got rdy=%b act=%b start=%b err=%b exp 1 0 0 %b",
                     ready_out, xfer_active, exec_start, op_err, exp_err);
        end
        op_in = 4'b0000; op_valid_in = 1'b1;
        cyc();
        op_valid_in = 1'b0;
        cyc();
        checks++;
        if (ready_out !== 1'b1 || exec_start !== 1'b0 || op_err !== exp_err) begin
            errors++;
            $display("FAIL illegal_sticky got rdy=%b start=%b err=%b exp 1 0 %b", ready_out, exec_start, op_err, exp_err);
        end
    endtask

    task automatic test_reset_mid_xfer();
        op_in = 4'b1001; op_valid_in = 1'b1;
        cyc();
        op_valid_in = 1'b0;
        xfer_beat = 1'b1;
        repeat (300) cyc();
        checks++;
        if (xfer_idx !== 10'd300 || xfer_type !== 2'b01 || xfer_dir !== 1'b0) begin
            errors++;
            $display("FAIL sk_mid got idx=%0d type=%b dir=%b exp 300 01 0", xfer_idx, xfer_type, xfer_dir);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        xfer_beat = 1'b0;
        checks++;
        if (ready_out !== 1'b1 || xfer_idx !== 10'd0 || xfer_active !== 1'b0 ||
            xfer_type !== 2'b00 || exec_op !== 4'b0000 || op_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b idx=%0d act=%b type=%b op=%b err=%b exp 1 0 0 00 0000 0",
                     ready_out, xfer_idx, xfer_active, xfer_type, exec_op, op_err);
        end
    endtask

    initial begin
        cyc();
        test_reset();
        test_store_seed();
        test_kgen();
        test_keygen_seq();
        test_ignored();
        test_illegal();
        test_reset_mid_xfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lowres_cmd_responder.md
# lowres_cmd_responder

Command front-end inside the low-resource Dilithium core: the receiving end of the 4-bit `op_in` / `op_valid_in` / `ready_out` opcode channel driven by the host-side adapter. It accepts one opcode at a time and decodes it into a store (ingest), load (dump) or compute command. It sequences the datapath word counter for store/load, or the engine start/done handshake for compute, and raises `ready_out` again only when the command has finished.

## Interface
- `PK_WORDS`, 328: 32-bit words in a public-key transfer.
- `SK_WORDS`, 640: words in a secret-key transfer.
- `SIG_WORDS`, 605: words in a signature transfer.
- `SEED_WORDS`, 8: words in a seed transfer.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_in`  in  4  opcode from the adapter.
- `op_valid_in`  in  1  opcode valid.
- `ready_out`  out  1  responder idle, can accept an opcode.
- `xfer_active`  out  1  store/load in progress.
- `xfer_dir`  out  1  1 = store (ingest), 0 = load (dump).
- `xfer_type`  out  2  payload type: 00 PK, 01 SK, 10 SIG, 11 SEED.
- `xfer_idx`  out  10  index of the current word, 0-based.
- `xfer_beat`  in  1  datapath moved one word this cycle.
- `exec_start`  out  1  one-cycle pulse that starts the engine.
- `exec_op`  out  4  latched compute opcode; held stable through EXEC.
- `exec_done`  in  1  engine finished.
- `op_err`  out  1  illegal opcode sticky flag (only with `LOWRES_CMD_ERR_EN`).

## Operation
- Opcode decode:
  - `op_in[3]`=1: 2-bit opcode plus 2-bit payload type. `11xx` is STOR and `10xx` is LOAD; `op_in[1:0]` is the payload type.
  - `op_in[3]`=0: 4-bit opcode. `0000` IDLE (no-op). `0001` DIGEST_MSG, `0010` SIGN, `0011` SIGN_PRECOMP, `0100` VRFY, `0101` VRFY_PRECOMP and `0111` KGEN are compute. `0110` is illegal.
- States: IDLE, XFER, EXEC_START, EXEC_WAIT.
- IDLE:
  - `ready_out`=1. An opcode is accepted when `op_valid_in`=1 in IDLE.
  - STOR/LOAD: latch `xfer_dir`/`xfer_type`, clear the counter, go to XFER.
  - Compute: latch `exec_op`, go to EXEC_START.
  - `0000`: accepted, stay in IDLE.
  - Illegal: stay in IDLE (see Configuration).
- XFER:
  - `xfer_active`=1. Each `xfer_beat` increments `xfer_idx`.
  - A beat at `xfer_idx` = length(type)−1 returns to IDLE and clears `xfer_idx` to 0.
  - length: PK→`PK_WORDS`, SK→`SK_WORDS`, SIG→`SIG_WORDS`, SEED→`SEED_WORDS`.
- EXEC_START: `exec_start`=1 for exactly one cycle, then EXEC_WAIT.
- EXEC_WAIT: on `exec_done`=1 return to IDLE. `exec_done` is ignored in every other state.
- `op_valid_in` is ignored in every state except IDLE; no queueing.
- Reset, including mid-XFER or mid-EXEC: state IDLE, `xfer_idx`=0, `exec_op`=0, `xfer_dir`=0, `xfer_type`=0, `op_err`=0. The engine is not notified.

## Timing
- `ready_out` is decoded from the state register. It goes low the cycle after acceptance and goes high the cycle after the final beat or `exec_done`.
- A back-to-back opcode presented in the same cycle `ready_out` rises is accepted.
- Compute latency: `exec_start` is asserted 1 cycle after acceptance. The minimum is 3 cycles from acceptance to `ready_out` high, when `exec_done` arrives on the first EXEC_WAIT cycle.
- Transfer: N beats (no minimum gap) → `ready_out` high the cycle after the Nth beat.
- `xfer_beat` outside XFER is ignored.
- All outputs are registered or decoded from registers only; no combinational path from inputs to outputs.
- Reset values: `ready_out`=1 and every other output 0.

## Configuration
- `LOWRES_CMD_ERR_EN` defined:
  - An illegal opcode accepted in IDLE sets `op_err`. `op_err` stays set until reset.
  - The responder stays in IDLE and still accepts further opcodes.
- Not defined: `op_err` is tied to 0 and illegal opcodes are silently treated as `0000`.

## Structure
- `lowres_cmd_pkg` holds:
  - opcode constants (OPCODE_IDLE/STOR/LOAD/DIGEST_MSG/SIGN/SIGN_PRECOMP/VRFY/VRFY_PRECOMP/KGEN);
  - payload-type constants (PK/SK/SIG/SEED);
  - the `resp_state_t` enum.
- The adapter shares this package.
- Sub-module `lowres_beat_counter`: 10-bit counter with clear, increment and last-word compare against a length input.

## Test plan
- Reset, then STOR SEED (`1111`), then 8 beats → `ready_out` low from cycle +1. `xfer_idx` steps 0..7. `ready_out` is high the cycle after beat 8, with `xfer_idx`=0.
- KGEN (`0111`) → `exec_start` pulses 1 cycle after acceptance with `exec_op`=0111. With `exec_done` 50 cycles later, `ready_out` rises the next cycle.
- Adapter keygen sequence (STOR SEED, KGEN, LOAD SK `1001`, LOAD PK `1000`) issued on each `ready_out` rise → 640 and 328 beats are counted, and each opcode is accepted on its `ready_out` cycle.
- `op_valid_in` with LOAD SIG during EXEC_WAIT, and `exec_done` during XFER → both ignored; the state does not change.
- `0110` with `LOWRES_CMD_ERR_EN` → `op_err`=1 and stays in IDLE. Without the macro → no effect, and `op_err`=0.
- Reset asserted at beat 300 of LOAD SK → next cycle: IDLE, `ready_out`=1, `xfer_idx`=0, `xfer_active`=0.
